// File: rtl/qed_mode_sequencer.sv
// qed_mode_sequencer: passes original instructions to decode while logging them,
// then replays them with r0-r15 remapped to r16-r31 and strobes the checker.
// Optional feature macro: QED_ROUND_CNT_EN (builds a saturating round counter).
module qed_mode_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INST_LIMIT = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] in_inst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        force_check,
  output logic [32:0] out_inst,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        mode,
  output logic        cmp_ena,
  output logic [15:0] round_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {ORIG, SETTLE1, CHECK, SETTLE2, DONE} state_t;

  state_t         state;
  logic [32:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [3:0]     settle_cnt;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           last_pop;
  logic           round_end;
  logic           settle_done;
  logic [CW-1:0]  occ_next;

  // Set bit 4 of rd, rs1 and (register form only) rs2 for format-2/3 instructions.
  function automatic logic [32:0] remap(input logic [32:0] i);
    logic [32:0] r;
    r = i;
    if (i[31]) begin
      r[29] = 1'b1;
      r[18] = 1'b1;
      if (!i[13]) r[4] = 1'b1;
    end
    return r;
  endfunction

  // FIFO status and round-boundary decode.
  always_comb begin
    full        = (count == CW'(DEPTH));
    empty       = (count == '0);
    push        = (state == ORIG) && in_vld && out_rdy && !full;
    pop         = (state == CHECK) && !empty && out_rdy;
    occ_next    = count + CW'(push);
    round_end   = (occ_next == CW'(INST_LIMIT)) || (force_check && (occ_next != '0));
    last_pop    = pop && (count == CW'(1));
    settle_done = (settle_cnt == 4'(SETTLE_CYC - 1));
  end

  // Log storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_inst;
  end

  // Sequencer state, FIFO pointers and settle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ORIG;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      settle_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
      case (state)
        ORIG: begin
          if (round_end) begin
            state      <= SETTLE1;
            settle_cnt <= '0;
          end
        end
        SETTLE1: begin
          if (settle_done) begin
            state      <= CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'(1);
          end
        end
        CHECK: begin
          if (last_pop) begin
            state      <= SETTLE2;
            settle_cnt <= '0;
          end
        end
        SETTLE2: begin
          if (settle_done) begin
            state      <= DONE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'(1);
          end
        end
        DONE:    state <= ORIG;
        default: state <= ORIG;
      endcase
    end
  end

  // Output steering; ORIG is a zero-latency pass-through, everything is 0 in reset.
  always_comb begin
    in_rdy   = 1'b0;
    out_inst = '0;
    out_vld  = 1'b0;
    mode     = 1'b0;
    cmp_ena  = 1'b0;
    if (!rst) begin
      case (state)
        ORIG: begin
          out_inst = in_inst;
          out_vld  = in_vld;
          in_rdy   = out_rdy && !full;
        end
        CHECK: begin
          out_inst = remap(mem[rd_ptr]);
          out_vld  = !empty;
          mode     = 1'b1;
        end
        SETTLE2: mode = 1'b1;
        DONE: begin
          mode    = 1'b1;
          cmp_ena = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef QED_ROUND_CNT_EN
  logic [15:0] cnt_q;

  // Completed-round counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state == DONE) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'(1);
    end
  end

  assign round_cnt = rst ? 16'(0) : cnt_q;
`else
  assign round_cnt = '0;
`endif

endmodule

// File: tb/tb_qed_mode_sequencer.sv
// Testbench for qed_mode_sequencer: directed scenarios plus random traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_qed_mode_sequencer;

  localparam int DEPTH  = 8;
  localparam int LIMIT  = 8;
  localparam int SETTLE = 4;

  localparam int P_ORIG = 0;
  localparam int P_S1   = 1;
  localparam int P_CHK  = 2;
  localparam int P_S2   = 3;
  localparam int P_DONE = 4;

  logic        clk;
  logic        rst;
  logic [32:0] in_inst;
  logic        in_vld;
  logic        in_rdy;
  logic        force_check;
  logic [32:0] out_inst;
  logic        out_vld;
  logic        out_rdy;
  logic        mode;
  logic        cmp_ena;
  logic [15:0] round_cnt;

  int checks = 0;
  int errors = 0;

  qed_mode_sequencer #(.DEPTH(DEPTH), .INST_LIMIT(LIMIT), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .in_inst(in_inst), .in_vld(in_vld), .in_rdy(in_rdy),
    .force_check(force_check), .out_inst(out_inst), .out_vld(out_vld),
    .out_rdy(out_rdy), .mode(mode), .cmp_ena(cmp_ena), .round_cnt(round_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Register operands r0-r15 become r16-r31 for format-2/3 instructions.
  function automatic logic [32:0] ref_remap(input logic [32:0] x);
    logic [32:0] m;
    m = '0;
    if (x[31]) begin
      m = 33'h020040000;
      if (!x[13]) m = m | 33'h000000010;
    end
    return x | m;
  endfunction

  function automatic logic [32:0] rand_orig();
    logic [32:0] x;
    x = {1'($urandom), 32'($urandom)};
    x[29] = 1'b0;
    x[18] = 1'b0;
    if (!x[13]) x[4] = 1'b0;
    return x;
  endfunction

  // Reference model: logged instructions, current phase, remaining settle cycles.
  logic [32:0] q[$];
  int ph = P_ORIG;
  int wl = 0;
  int rounds = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ph = P_ORIG;
      wl = 0;
      rounds = 0;
    end else begin
      case (ph)
        P_ORIG: begin
          if (in_vld && out_rdy && q.size() < DEPTH) q.push_back(in_inst);
          if (q.size() == LIMIT || (force_check && q.size() > 0)) begin
            ph = P_S1;
            wl = SETTLE;
          end
        end
        P_S1: begin
          wl--;
          if (wl == 0) ph = P_CHK;
        end
        P_CHK: begin
          if (out_rdy) void'(q.pop_front());
          if (q.size() == 0) begin
            ph = P_S2;
            wl = SETTLE;
          end
        end
        P_S2: begin
          wl--;
          if (wl == 0) ph = P_DONE;
        end
        default: begin
          rounds++;
          ph = P_ORIG;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [32:0] e_inst;
    logic        e_vld, e_rdy, e_mode, e_cmp;
    logic [15:0] e_rc;
    e_inst = '0; e_vld = 0; e_rdy = 0; e_mode = 0; e_cmp = 0; e_rc = '0;
    if (!rst) begin
`ifdef QED_ROUND_CNT_EN
      e_rc = (rounds > 65535) ? 16'hFFFF : 16'(rounds);
`endif
      case (ph)
        P_ORIG: begin
          e_inst = in_inst;
          e_vld  = in_vld;
          e_rdy  = out_rdy && (q.size() < DEPTH);
        end
        P_CHK: begin
          e_mode = 1;
          if (q.size() > 0) begin
            e_inst = ref_remap(q[0]);
            e_vld  = 1;
          end
        end
        P_S2:    e_mode = 1;
        P_DONE:  begin e_mode = 1; e_cmp = 1; end
        default: ;
      endcase
    end
    chk("cyc_out_inst", out_inst, e_inst);
    chk("cyc_out_vld", 33'(out_vld), 33'(e_vld));
    chk("cyc_in_rdy", 33'(in_rdy), 33'(e_rdy));
    chk("cyc_mode", 33'(mode), 33'(e_mode));
    chk("cyc_cmp_ena", 33'(cmp_ena), 33'(e_cmp));
    chk("cyc_round_cnt", 33'(round_cnt), 33'(e_rc));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_mode(input logic v, output int n);
    n = 1;
    #2;
    while (mode !== v && n < 40) begin
      step();
      #2;
      n++;
    end
  endtask

  task automatic wait_for_cmp(output int n);
    n = 1;
    #2;
    while (cmp_ena !== 1'b1 && n < 40) begin
      step();
      #2;
      n++;
    end
  endtask

  initial begin
    int n, pushes, idx, reps, cmps;
    logic prev_stall;
    logic [32:0] prev_inst;
    logic [32:0] exp_list[$];

    rst = 1; out_rdy = 1; in_vld = 1; in_inst = 33'h1FFFFFFFF; force_check = 0;
    repeat (3) step();
    #2;
    chk("rst_in_rdy", 33'(in_rdy), 33'd0);
    chk("rst_out_vld", 33'(out_vld), 33'd0);
    chk("rst_out_inst", out_inst, 33'd0);
    chk("rst_mode", 33'(mode), 33'd0);
    chk("rst_cmp_ena", 33'(cmp_ena), 33'd0);
    chk("rst_round_cnt", 33'(round_cnt), 33'd0);
    step();
    rst = 0; in_vld = 0; in_inst = '0;

    // Register-form remap, one-entry round via force_check.
    step();
    in_vld = 1; in_inst = 33'h082008003; force_check = 1;
    #2;
    chk("a_passthru", out_inst, 33'h082008003);
    chk("a_in_rdy", 33'(in_rdy), 33'd1);
    step();
    in_vld = 0; force_check = 0; in_inst = '0;
    wait_for_mode(1'b1, n);
    chk("a_mode_latency", 33'(n), 33'd5);
    chk("a_replay", out_inst, 33'h0A2048013);
    chk("a_replay_vld", 33'(out_vld), 33'd1);
    step();
    wait_for_cmp(n);
    chk("a_cmp_latency", 33'(n), 33'd5);
    step();
    #2;
    chk("a_mode_release", 33'(mode), 33'd0);

    // Immediate form and format-0 pass-through.
    step();
    in_vld = 1; in_inst = 33'h08200A005;
    step();
    in_inst = 33'h001000000; force_check = 1;
    step();
    in_vld = 0; force_check = 0;
    wait_for_mode(1'b1, n);
    chk("b_imm", out_inst, 33'h0A204A005);
    step();
    #2;
    chk("b_nop", out_inst, 33'h001000000);
    chk("b_nop_vld", 33'(out_vld), 33'd1);
    step();
    wait_for_cmp(n);
    chk("b_cmp", 33'(cmp_ena), 33'd1);

    // Full FIFO with continuous valid, then stalled replay.
    step();
    in_vld = 1; out_rdy = 1; pushes = 0;
    for (int i = 0; i < 10; i++) begin
      in_inst = rand_orig();
      #2;
      if (in_vld && in_rdy) begin
        pushes++;
        exp_list.push_back(in_inst);
      end
      step();
    end
    in_vld = 0;
    #2;
    chk("c_pushes", 33'(pushes), 33'd8);
    chk("c_in_rdy_blocked", 33'(in_rdy), 33'd0);
    idx = 0; n = 0; prev_stall = 0; prev_inst = '0;
    while (idx < 8 && n < 60) begin
      step();
      out_rdy = (n % 2 == 0);
      #2;
      if (mode && out_vld) begin
        if (prev_stall) chk("c_hold", out_inst, prev_inst);
        if (out_rdy) begin
          chk("c_order", out_inst, ref_remap(exp_list[idx]));
          idx++;
        end
        prev_stall = !out_rdy;
        prev_inst  = out_inst;
      end
      n++;
    end
    chk("c_replays", 33'(idx), 33'd8);
    out_rdy = 1;
    step();
    wait_for_cmp(n);
    chk("c_cmp", 33'(cmp_ena), 33'd1);

    // force_check with three entries.
    step();
    in_vld = 1;
    for (int i = 0; i < 3; i++) begin
      in_inst = rand_orig();
      force_check = (i == 2);
      step();
    end
    in_vld = 0; force_check = 0;
    wait_for_mode(1'b1, n);
    reps = 0; n = 0;
    while (cmp_ena !== 1'b1 && n < 40) begin
      if (mode && out_vld) reps++;
      step();
      #2;
      n++;
    end
    chk("d_replays", 33'(reps), 33'd3);
    chk("d_cmp", 33'(cmp_ena), 33'd1);

    // force_check with an empty FIFO is ignored.
    step();
    in_vld = 0; force_check = 1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("e_mode", 33'(mode), 33'd0);
      chk("e_in_rdy", 33'(in_rdy), 33'(out_rdy));
      step();
    end
    force_check = 0;
    #2;
`ifdef QED_ROUND_CNT_EN
    chk("round_cnt_four", 33'(round_cnt), 33'd4);
`else
    chk("round_cnt_tied", 33'(round_cnt), 33'd0);
`endif

    // Reset during CHECK aborts the round.
    step();
    in_vld = 1; in_inst = rand_orig();
    step();
    in_inst = rand_orig(); force_check = 1;
    step();
    in_vld = 0; force_check = 0; out_rdy = 0;
    wait_for_mode(1'b1, n);
    chk("f_in_check", 33'(mode), 33'd1);
    step();
    rst = 1; out_rdy = 1;
    #2;
    chk("f_rst_mode", 33'(mode), 33'd0);
    chk("f_rst_out_vld", 33'(out_vld), 33'd0);
    chk("f_rst_out_inst", out_inst, 33'd0);
    chk("f_rst_in_rdy", 33'(in_rdy), 33'd0);
    step();
    rst = 0;
    #2;
    chk("f_post_mode", 33'(mode), 33'd0);
    chk("f_post_in_rdy", 33'(in_rdy), 33'd1);
    cmps = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      #2;
      if (cmp_ena) cmps++;
    end
    chk("f_no_cmp", 33'(cmps), 33'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst         = ($urandom % 400 == 0);
      in_vld      = ($urandom % 4 != 0);
      out_rdy     = ($urandom % 3 != 0);
      force_check = ($urandom % 16 == 0);
      in_inst     = rand_orig();
    end
    step();
    rst = 0; in_vld = 0; force_check = 0; out_rdy = 1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
